// File: rtl/ro_mon_ctrl.sv
// Ring-oscillator process-monitor sequencer: settles one oscillator, counts its edges over a window.
// Optional overflow flag output OVF is compiled in when RO_MON_OVF_FLAG_EN is defined.
module ro_mon_ctrl #(
    parameter int N_RO   = 4,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 8
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic                     START,
    input  logic                     SWEEP,
    input  logic [$clog2(N_RO)-1:0]  RO_SEL,
    input  logic [WIN_W-1:0]         WINDOW,
    input  logic [N_RO-1:0]          RO_IN,
    output logic [N_RO-1:0]          RO_EN,
    output logic                     BUSY,
    output logic                     VALID,
    output logic [$clog2(N_RO)-1:0]  RO_ID,
    output logic [CNT_W-1:0]         COUNT
`ifdef RO_MON_OVF_FLAG_EN
    ,
    output logic                     OVF
`endif
);

    localparam int SEL_W = $clog2(N_RO);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_RO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               sweep_q, sweep_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEL_W-1:0]   ro_id_q, ro_id_d;
`ifdef RO_MON_OVF_FLAG_EN
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
`endif

    // Two-flop synchronizer followed by a history flop for edge detection.
    logic               ro_mux;
    logic               sync1_q, sync2_q, hist_q;
    logic               ro_edge;

    assign ro_mux  = RO_IN[idx_q];
    assign ro_edge = sync2_q & ~hist_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= ro_mux;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            sweep_q      <= 1'b0;
            win_q        <= '0;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            cnt_q        <= '0;
            count_q      <= '0;
            ro_id_q      <= '0;
`ifdef RO_MON_OVF_FLAG_EN
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sweep_q      <= sweep_d;
            win_q        <= win_d;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            cnt_q        <= cnt_d;
            count_q      <= count_d;
            ro_id_q      <= ro_id_d;
`ifdef RO_MON_OVF_FLAG_EN
            sat_q        <= sat_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sweep_d      = sweep_q;
        win_d        = win_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        cnt_d        = cnt_q;
        count_d      = count_q;
        ro_id_d      = ro_id_q;
`ifdef RO_MON_OVF_FLAG_EN
        sat_d        = sat_q;
        ovf_d        = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sweep_d      = SWEEP;
                    win_d        = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
                    if (SWEEP)
                        idx_d = '0;
                    else
                        idx_d = (RO_SEL > LAST_IDX) ? LAST_IDX : RO_SEL;
                    settle_cnt_d = SET_W'(SETTLE - 1);
                    state_d      = S_SETTLE;
                end
            end

            S_SETTLE: begin
                cnt_d = '0;
`ifdef RO_MON_OVF_FLAG_EN
                sat_d = 1'b0;
`endif
                if (settle_cnt_q == '0) begin
                    win_cnt_d = win_q - WIN_W'(1);
                    state_d   = S_MEASURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end

            S_MEASURE: begin
                if (ro_edge) begin
                    if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef RO_MON_OVF_FLAG_EN
                    else
                        sat_d = 1'b1;
`endif
                end
                // Results are captured on the last window cycle so they are stable during DONE.
                if (win_cnt_q == '0) begin
                    count_d = cnt_d;
                    ro_id_d = idx_q;
`ifdef RO_MON_OVF_FLAG_EN
                    ovf_d   = sat_d;
`endif
                    state_d = S_DONE;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end

            S_DONE: begin
                if (sweep_q && (idx_q != LAST_IDX)) begin
                    idx_d        = idx_q + SEL_W'(1);
                    settle_cnt_d = SET_W'(SETTLE - 1);
                    state_d      = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    logic ro_active;
    assign ro_active = (state_q == S_SETTLE) || (state_q == S_MEASURE);

    genvar gi;
    generate
        for (gi = 0; gi < N_RO; gi++) begin : g_ro_en
            assign RO_EN[gi] = ro_active && (idx_q == SEL_W'(gi));
        end
    endgenerate

    assign BUSY  = (state_q != S_IDLE);
    assign VALID = (state_q == S_DONE);
    assign RO_ID = ro_id_q;
    assign COUNT = count_q;
`ifdef RO_MON_OVF_FLAG_EN
    assign OVF   = ovf_q;
`endif

endmodule
